// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing generator with four selectable test patterns.
//   clk, rst            : single clock, synchronous active-high reset
//   btn_r/g/b           : asynchronous push buttons; each rising edge bumps a colour channel
//   mode[1:0]           : pattern select, adopted at the first pixel of each frame
//   out_r/g/b           : registered pixel colour (0 outside the active region)
//   hsync, vsync        : sync pulses at level SYNC_POL
//   de, pix_x, pix_y    : active-region flag and coordinates (0 outside the active region)
//   frame_start         : one-clk pulse with the output update for pixel (0,0)
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_r,
  input  logic               btn_g,
  input  logic               btn_b,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] out_r,
  output logic [COLOR_W-1:0] out_g,
  output logic [COLOR_W-1:0] out_b,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [10:0]        pix_x,
  output logic [9:0]         pix_y,
  output logic               frame_start
);

  localparam int unsigned HCW     = 11;
  localparam int unsigned VCW     = 10;
  localparam int unsigned PW      = HCW + 3;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HCW-1:0]   H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0]   V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0]   H_ACT_W  = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0]   V_ACT_W  = VCW'(V_ACTIVE);
  localparam logic [HCW-1:0]   HS_BEG   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0]   HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0]   VS_BEG   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0]   VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PW-1:0]    BAR_DEN  = PW'(H_ACTIVE);
  localparam logic             SYNC_LVL = 1'(SYNC_POL);
  localparam logic [COLOR_W-1:0] ONES   = '1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [HCW-1:0]     hcnt_q, hcnt_d;
  logic [VCW-1:0]     vcnt_q, vcnt_d;
  logic [2:0]         btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_prev_q, btn_prev_d;
  logic [COLOR_W-1:0] chan_r_q, chan_r_d, chan_g_q, chan_g_d, chan_b_q, chan_b_d;
  logic [1:0]         mode_act_q, mode_act_d;
  logic [COLOR_W-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
  logic [HCW-1:0]     pix_x_q, pix_x_d;
  logic [VCW-1:0]     pix_y_q, pix_y_d;

  logic               tick_c, first_c, active_c;
  logic [2:0]         edge_c;
  logic [1:0]         mode_eff_c;
  logic [PW-1:0]      bar_num_c;
  logic [2:0]         bar_c;
  logic [COLOR_W-1:0] pr_c, pg_c, pb_c;

  // Next-state: pixel tick, counters, button channels, mode latch, output update
  always_comb begin
    div_d      = div_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    btn_s1_d   = {btn_r, btn_g, btn_b};
    btn_s2_d   = btn_s1_q;
    btn_prev_d = btn_s2_q;
    out_r_d    = out_r_q;
    out_g_d    = out_g_q;
    out_b_d    = out_b_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    de_d       = de_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    fs_d       = 1'b0;
    pr_c       = '0;
    pg_c       = '0;
    pb_c       = '0;

    tick_c = (div_q == '0);
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    // Button edges are independent of the pixel tick
    edge_c   = btn_s2_q & ~btn_prev_q;
    chan_r_d = chan_r_q + COLOR_W'(edge_c[2]);
    chan_g_d = chan_g_q + COLOR_W'(edge_c[1]);
    chan_b_d = chan_b_q + COLOR_W'(edge_c[0]);

    // New mode applies from the very first pixel of the frame it is sampled at
    first_c    = tick_c && (hcnt_q == '0) && (vcnt_q == '0);
    mode_eff_c = first_c ? mode : mode_act_q;
    mode_act_d = mode_eff_c;

    active_c  = (hcnt_q < H_ACT_W) && (vcnt_q < V_ACT_W);
    bar_num_c = {hcnt_q, 3'b000};
    bar_c     = 3'(bar_num_c / BAR_DEN);

    unique case (mode_eff_c)
      2'd0: begin
        pr_c = chan_r_q; pg_c = chan_g_q; pb_c = chan_b_q;
      end
      2'd1: begin
        pr_c = bar_c[2] ? ONES : '0;
        pg_c = bar_c[1] ? ONES : '0;
        pb_c = bar_c[0] ? ONES : '0;
      end
      2'd2: begin
        if (hcnt_q[5] ^ vcnt_q[5]) begin
          pr_c = ONES; pg_c = ONES; pb_c = ONES;
        end else begin
          pr_c = chan_r_q; pg_c = chan_g_q; pb_c = chan_b_q;
        end
      end
      default: begin
        pr_c = hcnt_q[COLOR_W+3:4];
        pg_c = hcnt_q[COLOR_W+3:4];
        pb_c = hcnt_q[COLOR_W+3:4];
      end
    endcase

    if (tick_c) begin
      out_r_d = active_c ? pr_c : '0;
      out_g_d = active_c ? pg_c : '0;
      out_b_d = active_c ? pb_c : '0;
      de_d    = active_c;
      pix_x_d = active_c ? hcnt_q : '0;
      pix_y_d = active_c ? vcnt_q : '0;
      hsync_d = ((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)) ? SYNC_LVL : ~SYNC_LVL;
      vsync_d = ((vcnt_q >= VS_BEG) && (vcnt_q < VS_END)) ? SYNC_LVL : ~SYNC_LVL;
      fs_d    = first_c;
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCW'(1);
      end else begin
        hcnt_d = hcnt_q + HCW'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
      chan_r_q   <= '0;
      chan_g_q   <= '0;
      chan_b_q   <= '0;
      mode_act_q <= '0;
      out_r_q    <= '0;
      out_g_q    <= '0;
      out_b_q    <= '0;
      hsync_q    <= ~SYNC_LVL;
      vsync_q    <= ~SYNC_LVL;
      de_q       <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_prev_q <= btn_prev_d;
      chan_r_q   <= chan_r_d;
      chan_g_q   <= chan_g_d;
      chan_b_q   <= chan_b_d;
      mode_act_q <= mode_act_d;
      out_r_q    <= out_r_d;
      out_g_q    <= out_g_d;
      out_b_q    <= out_b_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      de_q       <= de_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      fs_q       <= fs_d;
    end
  end

  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster: a reference model predicts every
// registered output per clk and queues it; a monitor compares on the falling edge.
module tb_vga_pattern_gen;

  localparam int HA = 64, HFP = 4, HS = 6, HB = 6, HT = HA + HFP + HS + HB;
  localparam int VA = 40, VFP = 2, VS = 3, VB = 3, VT = VA + VFP + VS + VB;
  localparam int DIV = 2;
  localparam int FRAME_CLK = HT * VT * DIV;
  localparam logic SP = 1'b0;

  typedef struct packed {
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] px;
    logic [9:0]  py;
    logic        fs;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_r, btn_g, btn_b;
  logic [1:0]  mode;
  logic [3:0]  out_r, out_g, out_b;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(4), .CLK_DIV(DIV), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .btn_r(btn_r), .btn_g(btn_g), .btn_b(btn_b), .mode(mode),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .hsync(hsync), .vsync(vsync),
    .de(de), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  int   fs_exp = 0, fs_seen = 0;
  obs_t exp_q[$];

  // Model state
  int         cyc = 0, run_cyc = 0, k = 0;
  int         chan[3];
  int         mode_act = 0;
  logic [2:0] btn_prev = 3'b000;
  int         pend_at[$];
  int         pend_ch[$];
  obs_t       last_exp;

  // Expected output for raster position (h,v) under mode m and channel values c*
  function automatic obs_t model_pixel(int h, int v, int m, int cr, int cg, int cb);
    obs_t o;
    int   bar;
    o    = '0;
    o.hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : !SP;
    o.vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : !SP;
    if (h < HA && v < VA) begin
      o.de = 1'b1;
      o.px = 11'(h);
      o.py = 10'(v);
      case (m)
        0: begin o.r = 4'(cr); o.g = 4'(cg); o.b = 4'(cb); end
        1: begin
          bar = h * 8 / HA;
          o.r = ((bar >> 2) & 1) != 0 ? 4'hF : 4'h0;
          o.g = ((bar >> 1) & 1) != 0 ? 4'hF : 4'h0;
          o.b = (bar & 1) != 0 ? 4'hF : 4'h0;
        end
        2: begin
          if ((((h >> 5) ^ (v >> 5)) & 1) != 0) begin
            o.r = 4'hF; o.g = 4'hF; o.b = 4'hF;
          end else begin
            o.r = 4'(cr); o.g = 4'(cg); o.b = 4'(cb);
          end
        end
        default: begin
          o.r = 4'((h >> 4) & 15); o.g = 4'((h >> 4) & 15); o.b = 4'((h >> 4) & 15);
        end
      endcase
    end
    return o;
  endfunction

  // Reference model: one expected output record per clk edge
  always @(posedge clk) begin
    obs_t       e;
    logic [2:0] bn;
    int         pos, h, v;
    cyc++;
    bn = {btn_r, btn_g, btn_b};
    if (rst) begin
      run_cyc  = 0;
      k        = 0;
      mode_act = 0;
      chan     = '{0, 0, 0};
      pend_at.delete();
      pend_ch.delete();
      btn_prev = 3'b000;
      e        = '0;
      e.hs     = !SP;
      e.vs     = !SP;
    end else begin
      // A rising edge seen here reaches the colour path three clks later
      for (int i = 0; i < 3; i++) begin
        if (bn[i] && !btn_prev[i]) begin
          pend_at.push_back(cyc + 3);
          pend_ch.push_back(i);
        end
      end
      btn_prev = bn;
      while (pend_at.size() > 0 && pend_at[0] <= cyc) begin
        void'(pend_at.pop_front());
        h = pend_ch.pop_front();
        chan[h] = (chan[h] + 1) % 16;
      end
      if (run_cyc % DIV == 0) begin
        pos = k % (HT * VT);
        h   = pos % HT;
        v   = pos / HT;
        if (pos == 0) mode_act = int'(mode);
        // chan[] index: 2=red, 1=green, 0=blue
        e    = model_pixel(h, v, mode_act, chan[2], chan[1], chan[0]);
        e.fs = (pos == 0);
        if (pos == 0) fs_exp++;
        k++;
      end else begin
        e    = last_exp;
        e.fs = 1'b0;
      end
      run_cyc++;
    end
    last_exp = e;
    exp_q.push_back(e);
  end

  // Monitor: compare the registered outputs against the oldest expectation
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{r: out_r, g: out_g, b: out_b, hs: hsync, vs: vsync, de: de,
            px: pix_x, py: pix_y, fs: frame_start};
      if (frame_start === 1'b1) fs_seen++;
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got rgb=%h/%h/%h hs=%b vs=%b de=%b x=%0d y=%0d fs=%b want rgb=%h/%h/%h hs=%b vs=%b de=%b x=%0d y=%0d fs=%b",
                 $time, a.r, a.g, a.b, a.hs, a.vs, a.de, a.px, a.py, a.fs,
                 e.r, e.g, e.b, e.hs, e.vs, e.de, e.px, e.py, e.fs);
      end
    end
  end

  task automatic press(input logic [2:0] m, input int hold, input int gap);
    {btn_r, btn_g, btn_b} = m;
    repeat (hold) @(negedge clk);
    {btn_r, btn_g, btn_b} = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int  spent, gap;
    bit  did_rst;
    rst = 1'b1;
    {btn_r, btn_g, btn_b} = 3'b000;
    mode = 2'd0;
    did_rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Seventeen red presses wrap the 4-bit channel to 1
    repeat (17) press(3'b100, 4, 4);

    // Each segment holds one mode for a full frame with random button activity
    for (int s = 0; s < 7; s++) begin
      mode  = 2'(s % 4);
      spent = 0;
      while (spent < FRAME_CLK) begin
        gap = int'($urandom_range(100, 900));
        repeat (gap) @(negedge clk);
        spent += gap;
        if (s == 3 && !did_rst && spent > 3000) begin
          rst = 1'b1;
          repeat (3) @(negedge clk);
          rst = 1'b0;
          did_rst = 1'b1;
          spent += 3;
        end else begin
          press(3'($urandom_range(1, 7)), 4, 4);
          spent += 8;
        end
      end
    end
    repeat (20) @(negedge clk);

    n_chk++;
    if (fs_seen != fs_exp) begin
      n_fail++;
      $display("FAIL frame_start_count got %0d want %0d", fs_seen, fs_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
